// File: rtl/uart_rx_os_if.sv
// uart_rx_os_if: received-word valid/ready channel carrying parity, framing and overrun status.
interface uart_rx_os_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_valid;
   logic                  rx_ready;
   logic                  rx_parity_err;
   logic                  rx_frame_err;
   logic                  rx_overrun;
   modport master (
      output rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun,
      input  rx_ready
   );
   modport slave (
      input  rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun,
      output rx_ready
   );
endinterface

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver (start, LSB-first data, [odd parity], stop) onto valid/ready.
// Define UART_RX_PARITY_EN to expect and check an odd-parity bit between data and stop.
module uart_rx_os #(
   parameter int DATA_WIDTH = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic         uart_clk,
   input  logic         rst,
   input  logic         rx_in,
   output logic         rx_busy,
   uart_rx_os_if.master bus
);
   localparam int CW = $clog2(OVERSAMPLE);
   localparam int IW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(OVERSAMPLE - 1);
   localparam logic [IW-1:0] LAST = IW'(DATA_WIDTH - 1);
   typedef enum logic [2:0] {
      IDLE, START, DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP, BREAK
   } state_t;
   state_t                state, state_n;
   logic [CW-1:0]         cnt, cnt_n;
   logic [IW-1:0]         idx, idx_n;
   logic                  s1, rx_s;
   logic [DATA_WIDTH-1:0] sh, data_q;
   logic                  valid_q, perr_q, ferr_q, ovr_q;
   logic                  shift_en, dlv, perr_n;
`ifdef UART_RX_PARITY_EN
   logic                  par_q, par_en;
   assign perr_n = ~^{sh, par_q};
`else
   assign perr_n = 1'b0;
`endif
   assign rx_busy           = state != IDLE;
   assign bus.rx_data       = data_q;
   assign bus.rx_valid      = valid_q;
   assign bus.rx_parity_err = perr_q;
   assign bus.rx_frame_err  = ferr_q;
   assign bus.rx_overrun    = ovr_q;
   always_ff @(posedge uart_clk or posedge rst)
      if (rst) {s1, rx_s} <= 2'b11;
      else     {s1, rx_s} <= {rx_in, s1};
   always_ff @(posedge uart_clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
      end
   // Samples land at bit centres: half a bit after the start edge, then every full bit.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt + 1'b1;
      idx_n    = idx;
      shift_en = 1'b0;
      dlv      = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_en   = 1'b0;
`endif
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (!rx_s) state_n = START;
         end
         START: if (cnt == MID) begin
            cnt_n   = '0;
            state_n = rx_s ? IDLE : DATA;
         end
         DATA: if (cnt == FULL) begin
            cnt_n    = '0;
            shift_en = 1'b1;
            idx_n    = idx + 1'b1;
            if (idx == LAST) begin
               idx_n = '0;
`ifdef UART_RX_PARITY_EN
               state_n = PARITY;
`else
               state_n = STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: if (cnt == FULL) begin
            cnt_n   = '0;
            par_en  = 1'b1;
            state_n = STOP;
         end
`endif
         STOP: if (cnt == FULL) begin
            cnt_n   = '0;
            dlv     = 1'b1;
            state_n = rx_s ? IDLE : BREAK;
         end
         BREAK: begin
            cnt_n = '0;
            if (rx_s) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
   // A delivery into an unconsumed word is dropped and flagged; a same-cycle consume makes room.
   always_ff @(posedge uart_clk or posedge rst)
      if (rst) begin
         sh      <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         ovr_q <= 1'b0;
         if (shift_en) sh <= {rx_s, sh[DATA_WIDTH-1:1]};
`ifdef UART_RX_PARITY_EN
         if (par_en) par_q <= rx_s;
`endif
         if (dlv && (!valid_q || bus.rx_ready)) begin
            data_q  <= sh;
            perr_q  <= perr_n;
            ferr_q  <= !rx_s;
            valid_q <= 1'b1;
         end else if (dlv) ovr_q <= 1'b1;
         else if (valid_q && bus.rx_ready) valid_q <= 1'b0;
      end
endmodule
